// File: rtl/seq_div_16.sv
// 16-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Results are registered only at the end and held until the next completion.
module seq_div_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [15:0] dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [15:0] dsr;
  logic [15:0] prem;
  logic [16:0] trial_in, trial;
  logic        ge;
  logic [15:0] prem_nxt, q_nxt;
  logic        accept;

  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // prem < dsr always holds, so trial_in < 2*dsr and bit 16 of the
  // difference is set exactly when the subtraction would go negative.
  always_comb begin
    trial_in = {prem, dvd[15]};
    trial    = trial_in - {1'b0, dsr};
    ge       = ~trial[16];
    prem_nxt = ge ? trial[15:0] : trial_in[15:0];
    q_nxt    = {dvd[14:0], ge};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == 16'd0) ? DONE : RUN;
      RUN:  if (cnt == 5'd15) state_nxt = DONE;
      DONE: begin
        if (start) state_nxt = (divisor == 16'd0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor == 16'd0) begin
        quotient    <= 16'hFFFF;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        dvd  <= dividend;
        dsr  <= divisor;
        prem <= '0;
        cnt  <= '0;
      end
    end else if (state == RUN) begin
      dvd  <= q_nxt;
      prem <= prem_nxt;
      cnt  <= cnt + 5'd1;
      if (cnt == 5'd15) begin
        quotient    <= q_nxt;
        remainder   <= prem_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_div_16.sv
// Directed and random checks of seq_div_16 against plain / and % arithmetic.
`timescale 1ns/1ps
module tb_seq_div_16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int n_assert = 0;
  int n_fail   = 0;

  seq_div_16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 0) ? 16'hFFFF : 16'(a / b);
  endfunction

  function automatic logic [15:0] ref_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 0) ? a : 16'(a % b);
  endfunction

  // Wait for done after an accepting edge; returns negedges elapsed and busy count.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy && done) check("busy_and_done", 1, 0);
      if (done) return;
      if (busy) bcnt++;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    wait_done(lat, bcnt);
    check({tag, "_lat"}, lat, (b == 0) ? 1 : 17);
    check({tag, "_busy"}, bcnt, (b == 0) ? 0 : 16);
    check({tag, "_q"}, quotient, ref_q(a, b));
    check({tag, "_r"}, remainder, ref_r(a, b));
    check({tag, "_dbz"}, div_by_zero, (b == 0));
  endtask

  initial begin
    int lat, bcnt, ndone;
    logic [15:0] a, b;

    // reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    do_div("d100_7", 100, 7);
    do_div("dffff_1", 16'hFFFF, 1);
    do_div("d3_10", 3, 10);
    do_div("d5_0", 5, 0);
    do_div("d9_3", 9, 3);

    // start pulse in RUN ignored, operand changes ignored
    @(negedge clk);
    start = 1'b1; dividend = 1000; divisor = 9;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 50; divisor = 5;
    @(posedge clk); #1 start = 1'b0; dividend = 16'd7; divisor = 16'd0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ign_q", quotient, 111);
        check("ign_r", remainder, 1);
      end
    end
    check("ign_ndone", ndone, 1);

    // async reset mid-RUN
    @(negedge clk);
    start = 1'b1; dividend = 1000; divisor = 9;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_dbz", div_by_zero, 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("arst_nodone", ndone, 0);
    rst_n = 1'b1;
    do_div("d20_6", 20, 6);

    // back-to-back: start held through DONE
    @(negedge clk);
    start = 1'b1; dividend = 100; divisor = 7;
    @(posedge clk); #1 dividend = 40000; divisor = 200;
    wait_done(lat, bcnt);
    check("b2b1_lat", lat, 17);
    check("b2b1_q", quotient, 14);
    check("b2b1_r", remainder, 2);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("b2b_noidle", busy, 1);
    wait_done(lat, bcnt);
    check("b2b2_lat", lat, 16);
    check("b2b2_q", quotient, 200);
    check("b2b2_r", remainder, 0);
    check("b2b2_dbz", div_by_zero, 0);

    // random operands, occasionally zero or small divisors
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      do_div("rnd", a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
